// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Holds the FSM encoding and the address-check helper.
package dmem_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_WAIT = 2'b01,
    S_RESP = 2'b10
  } state_e;

  localparam int WORD_BYTES   = 4;
  localparam int CNT_W        = 4;
  localparam int ERR_MISALIGN = 0;
  localparam int ERR_RANGE    = 1;

  // One bit per error cause, indexed by the ERR_* positions.
  function automatic logic [1:0] adr_err(
    input logic [31:0] adr,
    input int unsigned aw
  );
    logic [1:0] e;
    e = '0;
    e[ERR_MISALIGN] = |adr[1:0];
    e[ERR_RANGE]    = (adr >> (aw + 2)) != 32'd0;
    return e;
  endfunction

endpackage

// File: rtl/dmem_wait_counter.sv
// Loadable down-counter pacing the wait states.
// Zero flag tells the FSM the last wait cycle is running.
module dmem_wait_counter
  import dmem_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] val_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = val_i;
    end else if (en_i && cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the CPU data port: one request
// at a time, fixed wait states, single registered response.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_W      = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_wr,
  input  logic [31:0] req_adr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);

  localparam logic [CNT_W-1:0] LOAD_V =
    (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

  state_e      state_q;
  logic        wr_q;
  logic [31:0] adr_q;
  logic [31:0] wdata_q;
  logic [31:0] mem_q [DEPTH];

  logic              cnt_load;
  logic              cnt_en;
  logic              cnt_zero;
  logic              wr_src;
  logic [31:0]       adr_src;
  logic [1:0]        err_src;
  logic              bad_src;
  logic [ADDR_W-1:0] idx_src;
  logic [ADDR_W-1:0] idx_q;
  logic [31:0]       rdata_src;

  // With zero wait states the response is built from the live request.
  assign wr_src    = (state_q == S_IDLE) ? req_wr  : wr_q;
  assign adr_src   = (state_q == S_IDLE) ? req_adr : adr_q;
  assign err_src   = adr_err(adr_src, ADDR_W);
  assign bad_src   = |err_src;
  assign idx_src   = adr_src[ADDR_W+1:2];
  assign idx_q     = adr_q[ADDR_W+1:2];
  assign rdata_src = (!wr_src && !bad_src) ? mem_q[idx_src] : '0;

  assign cnt_load = (state_q == S_IDLE) && req_valid
                    && (WAIT_CYCLES > 0);
  assign cnt_en   = (state_q == S_WAIT);

  dmem_wait_counter u_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (cnt_load),
    .en_i   (cnt_en),
    .val_i  (LOAD_V),
    .zero_o (cnt_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      wr_q       <= 1'b0;
      adr_q      <= '0;
      wdata_q    <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      busy       <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            wr_q      <= req_wr;
            adr_q     <= req_adr;
            wdata_q   <= req_wdata;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            if (WAIT_CYCLES > 0) begin
              state_q <= S_WAIT;
            end else begin
              state_q    <= S_RESP;
              resp_valid <= 1'b1;
              resp_rdata <= rdata_src;
              resp_err   <= bad_src;
            end
          end
        end
        S_WAIT: begin
          if (cnt_zero) begin
            state_q    <= S_RESP;
            resp_valid <= 1'b1;
            resp_rdata <= rdata_src;
            resp_err   <= bad_src;
          end
        end
        S_RESP: begin
          if (wr_q && !resp_err) begin
            mem_q[idx_q] <= wdata_q;
          end
          state_q    <= S_IDLE;
          req_ready  <= 1'b1;
          busy       <= 1'b0;
          resp_valid <= 1'b0;
          resp_rdata <= '0;
          resp_err   <= 1'b0;
        end
        default: begin
          state_q    <= S_IDLE;
          req_ready  <= 1'b1;
          busy       <= 1'b0;
          resp_valid <= 1'b0;
          resp_rdata <= '0;
          resp_err   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (2 and 0 wait states)
// against a word-array model of the memory.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rv [2];
  logic        rw [2];
  logic [31:0] ra [2];
  logic [31:0] rd [2];
  logic        rdy [2];
  logic        pv [2];
  logic [31:0] prd [2];
  logic        perr [2];
  logic        bsy [2];

  int checks = 0;
  int errors = 0;
  logic [31:0] model [2][64];
  int waits [2] = '{2, 0};

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(64), .WAIT_CYCLES(2), .ADDR_W(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(rv[0]), .req_wr(rw[0]),
    .req_adr(ra[0]), .req_wdata(rd[0]),
    .req_ready(rdy[0]), .resp_valid(pv[0]),
    .resp_rdata(prd[0]), .resp_err(perr[0]),
    .busy(bsy[0])
  );

  dmem_responder #(.DEPTH(64), .WAIT_CYCLES(0), .ADDR_W(6)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(rv[1]), .req_wr(rw[1]),
    .req_adr(ra[1]), .req_wdata(rd[1]),
    .req_ready(rdy[1]), .resp_valid(pv[1]),
    .resp_rdata(prd[1]), .resp_err(perr[1]),
    .busy(bsy[1])
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 64; i++) model[k][i] = '0;
  endtask

  // Issue one request on instance k and check timing and payload.
  task automatic xact(input int k, input logic wr,
                      input logic [31:0] adr,
                      input logic [31:0] wdata,
                      input logic garble);
    logic        bad;
    logic [31:0] exp_rd;
    int          n;
    bit          seen;
    bad = (adr[1:0] != 2'b00) || (adr[31:8] != 24'd0);
    exp_rd = (!wr && !bad) ? model[k][adr[7:2]] : 32'd0;
    @(negedge clk);
    chk($sformatf("ready_idle%0d", k), 32'(rdy[k]), 32'd1);
    chk($sformatf("pulse_end%0d", k), 32'(pv[k]), 32'd0);
    rv[k] = 1'b1; rw[k] = wr; ra[k] = adr; rd[k] = wdata;
    @(posedge clk);
    seen = 1'b0;
    n = 0;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      if (garble) begin
        rv[k] = 1'b1; rw[k] = $urandom_range(0, 1) == 1;
        ra[k] = $urandom; rd[k] = $urandom;
      end else begin
        rv[k] = 1'b0;
      end
      chk($sformatf("ready_busy%0d", k), 32'(rdy[k]), 32'd0);
      chk($sformatf("busy%0d", k), 32'(bsy[k]), 32'd1);
      if (pv[k]) seen = 1'b1;
    end
    rv[k] = 1'b0;
    chk($sformatf("latency%0d", k), 32'(n), 32'(waits[k] + 1));
    chk($sformatf("rdata%0d_%h", k, adr), prd[k], exp_rd);
    chk($sformatf("err%0d_%h", k, adr), 32'(perr[k]), 32'(bad));
    if (wr && !bad) model[k][adr[7:2]] = wdata;
  endtask

  function automatic logic [31:0] rand_adr();
    logic [31:0] a;
    a = $urandom_range(0, 63) * 4;
    case ($urandom_range(0, 7))
      0: a = a | 32'($urandom_range(1, 3));
      1: a = a | (32'd1 << $urandom_range(8, 31));
      default: ;
    endcase
    return a;
  endfunction

  initial begin
    for (int k = 0; k < 2; k++) begin
      rv[k] = 0; rw[k] = 0; ra[k] = 0; rd[k] = 0;
    end
    clear_model();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_ready", 32'(rdy[k]), 32'd1);
      chk("rst_busy", 32'(bsy[k]), 32'd0);
      chk("rst_valid", 32'(pv[k]), 32'd0);
      chk("rst_rdata", prd[k], 32'd0);
      chk("rst_err", 32'(perr[k]), 32'd0);
      xact(k, 1'b0, 32'h0, 32'h0, 1'b0);
    end

    for (int k = 0; k < 2; k++) begin
      xact(k, 1'b1, 32'h14, 32'hDEADBEEF, 1'b0);
      xact(k, 1'b0, 32'h14, 32'h0, 1'b0);
      xact(k, 1'b1, 32'h15, 32'h12345678, 1'b0);
      xact(k, 1'b0, 32'h14, 32'h0, 1'b0);
      xact(k, 1'b0, 32'h100, 32'h0, 1'b0);
      xact(k, 1'b1, 32'h20, 32'h0BADF00D, 1'b1);
      xact(k, 1'b0, 32'h20, 32'h0, 1'b1);
      xact(k, 1'b0, 32'h20, 32'h0, 1'b0);
    end

    for (int i = 0; i < 40; i++) begin
      int k;
      k = $urandom_range(0, 1);
      xact(k, $urandom_range(0, 1) == 1, rand_adr(),
           $urandom, $urandom_range(0, 3) == 0);
    end

    // Abort a store in its wait phase.
    @(negedge clk);
    rv[0] = 1'b1; rw[0] = 1'b1;
    ra[0] = 32'h08; rd[0] = 32'hCAFEF00D;
    @(posedge clk);
    @(negedge clk);
    rv[0] = 1'b0;
    rst_n = 1'b0;
    clear_model();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_valid", 32'(pv[0]), 32'd0);
      chk("abort_busy", 32'(bsy[0]), 32'd0);
      chk("abort_ready", 32'(rdy[0]), 32'd1);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_noresp", 32'(pv[0]), 32'd0);
    end
    xact(0, 1'b0, 32'h08, 32'h0, 1'b0);
    xact(1, 1'b0, 32'h08, 32'h0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the CPU data-memory port; it serves the other end of the load/store path driven by the datapath.
- Accepts one word load/store request at a time over a valid/ready handshake.
- Inserts a configurable number of wait states, then returns one response pulse carrying read data or an error flag.
- Replaces the zero-latency data memory so the CPU can later be made to stall on memory.

Parameters:
- DEPTH, 64: number of 32-bit words stored. Power of two, at least 2.
- WAIT_CYCLES, 2: wait states inserted between accept and response. Range 0..15.
- ADDR_W, 6: word-index width. Must equal log2(DEPTH).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_wr  in  1  1 = store (sw), 0 = load (lw).
- req_adr  in  32  byte address (ALU result).
- req_wdata  in  32  store data (busB).
- req_ready  out  1  responder can accept a request this cycle.
- resp_valid  out  1  one-cycle response pulse.
- resp_rdata  out  32  load data. 0 for stores and for errors.
- resp_err  out  1  request was misaligned or out of range. Qualified by resp_valid.
- busy  out  1  a request is in flight (state is not IDLE).

Behaviour:
- Reset (rst_n low, asynchronous):
  - state goes to IDLE and the wait counter clears to 0.
  - req_ready=1; resp_valid=0; resp_rdata=0; resp_err=0; busy=0.
  - All DEPTH storage words clear to 0.
- Reset asserted mid-operation aborts the in-flight request: no write is committed and no response is produced.
- State machine:
  - IDLE: req_ready=1. When req_valid is high at a clock edge, the request is accepted. Latch req_wr, req_adr and req_wdata. If WAIT_CYCLES>0, go to WAIT with counter=WAIT_CYCLES-1. Otherwise go to RESP.
  - WAIT: req_ready=0. Decrement the counter each cycle. When the counter is 0, go to RESP on the next edge.
  - RESP: resp_valid=1 for exactly one cycle and req_ready=0. A store commits on the edge that leaves RESP. Next state is IDLE.
- Latency: if accepted at edge T, resp_valid is high during cycle T+1+WAIT_CYCLES.
- Throughput: one request per WAIT_CYCLES+2 cycles.
- req_valid is ignored while not in IDLE. Request inputs may change freely after accept because they are latched.
- Address checks on the latched address:
  - Misaligned: adr[1:0] != 0.
  - Out of range: adr[31:ADDR_W+2] != 0.
  - Either case sets resp_err=1, forces resp_rdata=0 and suppresses any write.
- Word index is adr[ADDR_W+1:2].
- Load: resp_rdata is the stored word as of the RESP cycle. Storage is single-port; no read and write happen in the same cycle.
- Store: resp_rdata=0 and resp_err=0 if the address is valid.
- A load issued after a store to the same word returns the new data, because the store commits before IDLE re-accepts.
- No back-pressure on the response: the requester must consume resp_valid in the cycle it is high.
- Outside RESP, resp_rdata and resp_err are held at 0.

Decomposition:
- Shared package dmem_pkg:
  - State encoding: IDLE=2'b00, WAIT=2'b01, RESP=2'b10. 2'b11 is unreachable and recovers to IDLE.
  - Constant WORD_BYTES=4.
  - Error-cause localparams for the misaligned and out-of-range checks.
- One sub-module, dmem_wait_counter:
  - Loadable 4-bit down-counter with load, enable and zero-flag output.
  - Asynchronous active-low clear.
  - Instantiated once.
- Storage array, address check and FSM stay in dmem_responder.

Test Plan:
- Reset check: hold rst_n low 3 cycles, then release. Required: req_ready=1, busy=0, resp_valid=0. A load of adr 0x0 returns resp_rdata=0x00000000, resp_err=0.
- Store then load (WAIT_CYCLES=2): store 0xDEADBEEF to 0x14, accepted at edge T. Required: resp_valid in cycle T+3 only, req_ready low T+1..T+3. Then a load of 0x14 returns 0xDEADBEEF.
- Misaligned: store 0x12345678 to 0x15. Required: resp_err=1, resp_rdata=0. A later load of 0x14 still returns its prior value.
- Out of range (DEPTH=64): load 0x100. Required: resp_err=1, resp_rdata=0.
- Busy handling: hold req_valid high with changing adr/wdata during WAIT. Required: only the first request is served. A second request is accepted in the IDLE cycle after RESP.
- Reset mid-request: assert rst_n low during WAIT of a store 0xCAFEF00D to 0x08. Required: no resp_valid. A load of 0x08 after reset returns 0. Also rerun with WAIT_CYCLES=0: resp_valid appears at T+1.
